// File: rtl/dflow_replay_engine_mc.sv
// dflow_replay_engine_mc: multi-channel store/replay engine for the QDR user interface.
// Store mode writes tagged 5-tuple/length records into per-channel address windows.
// Replay mode reads the windows back round-robin. Each channel has its own loop count,
// and credit-based flow control keeps the output FIFO from overflowing.
//
// Handshakes: a transfer happens on a rising qdr_clk edge where both valid and ready
// are high. A source holds its data stable while valid && !ready. Valid never waits
// on ready. tuple_in_ready is the only output that is not a pure flop: it is
// !ch_full[tuple_in_ch], muxed from registered state by the incoming channel id.
module dflow_replay_engine_mc #(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 4,
  parameter int PKT_TUPLE_WIDTH = 104,
  parameter int PKT_LEN_WIDTH   = 16,
  parameter int QDR_ADDR_WIDTH  = 19,
  parameter int LOOP_WIDTH      = 16,
  parameter int OUT_DEPTH       = 32
) (
  input  logic                             qdr_clk,
  input  logic                             resetn,
  input  logic                             sw_rst,
  input  logic                             store_en,
  input  logic                             replay_en,
  input  logic [NUM_CH*QDR_ADDR_WIDTH-1:0] cfg_base,
  input  logic [NUM_CH*QDR_ADDR_WIDTH-1:0] cfg_limit,
  input  logic [NUM_CH*LOOP_WIDTH-1:0]     cfg_loops,
  output logic [NUM_CH-1:0]                ch_done,
  output logic [NUM_CH-1:0]                ch_full,
  output logic                             busy,
  output logic                             ovf_err,
  input  logic                             init_calib_complete,
  output logic                             user_app_wr_cmd,
  output logic [QDR_ADDR_WIDTH-1:0]        user_app_wr_addr,
  output logic [143:0]                     user_app_wr_data,
  output logic                             user_app_rd_cmd,
  output logic [QDR_ADDR_WIDTH-1:0]        user_app_rd_addr,
  input  logic                             user_app_rd_valid,
  input  logic [143:0]                     user_app_rd_data,
  input  logic [PKT_TUPLE_WIDTH-1:0]       tuple_in_data,
  input  logic [PKT_LEN_WIDTH-1:0]         tuple_in_len,
  input  logic [CH_W-1:0]                  tuple_in_ch,
  input  logic                             tuple_in_vld,
  output logic                             tuple_in_ready,
  output logic [PKT_TUPLE_WIDTH-1:0]       tuple_out_data,
  output logic [PKT_LEN_WIDTH-1:0]         tuple_out_len,
  output logic [CH_W-1:0]                  tuple_out_ch,
  output logic                             tuple_out_vld,
  input  logic                             tuple_out_ready,
  output logic [1:0]                       dbg_state
);

  localparam int AW    = QDR_ADDR_WIDTH;
  localparam int PAY_W = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH + CH_W;
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int PTR_W = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STORE  = 2'd1,
    S_REPLAY = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [NUM_CH-1:0][AW-1:0]      wptr_q, wptr_d;
  logic [NUM_CH-1:0][AW-1:0]      rptr_q, rptr_d;
  logic [NUM_CH-1:0][LOOP_WIDTH-1:0] left_q, left_d;
  logic [NUM_CH-1:0]              stored_q, stored_d;
  logic [NUM_CH-1:0]              ch_full_q, ch_full_d;
  logic [NUM_CH-1:0]              ch_done_q, ch_done_d;
  logic                           ovf_q, ovf_d;
  logic                           busy_q, busy_d;
  logic [CH_W-1:0]                last_q, last_d;
  logic [CNT_W-1:0]               outst_q, outst_d;
  logic [CNT_W-1:0]               fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]               fifo_rd_q, fifo_rd_d;
  logic [PTR_W-1:0]               fifo_wr_q, fifo_wr_d;
  logic [6:0]                     ign_q, ign_d;
  logic                           wr_cmd_q, wr_cmd_d;
  logic [AW-1:0]                  wr_addr_q, wr_addr_d;
  logic [143:0]                   wr_data_q, wr_data_d;
  logic                           rd_cmd_q, rd_cmd_d;
  logic [AW-1:0]                  rd_addr_q, rd_addr_d;
  logic                           out_vld_q, out_vld_d;
  logic [PAY_W-1:0]               out_pay_q, out_pay_d;

  logic [PAY_W-1:0]               fifo_mem [OUT_DEPTH];
  logic [2**CH_W-1:0]             full_ext;
  logic                           accept, issue, ret, push, pop, credit_ok;
  logic                           pick_found;
  int                             pick_idx;
  logic [PAY_W-1:0]               rd_pay;
  logic [CNT_W-1:0]               cnt_after_pop;
  logic                           unused_rd;

  // Upper QDR word bits are always zero on write and carry nothing on read.
  assign unused_rd = ^user_app_rd_data;
  assign rd_pay    = user_app_rd_data[PAY_W-1:0];

  // Widen ch_full so out-of-range channel ids read as "not full" (accept and discard).
  always_comb begin
    full_ext = '0;
    full_ext[NUM_CH-1:0] = ch_full_q;
  end

  assign tuple_in_ready = (state_q == S_STORE) && !full_ext[tuple_in_ch];
  assign accept         = tuple_in_vld && tuple_in_ready;
  assign pop            = out_vld_q && tuple_out_ready;
  assign credit_ok      = (outst_q + fifo_cnt_q) < CNT_W'(OUT_DEPTH);

  // Round-robin pick: first non-done channel after the last one that issued a read.
  always_comb begin
    int j;
    pick_found = 1'b0;
    pick_idx   = 0;
    j          = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = int'(last_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!pick_found && !ch_done_q[j]) begin
        pick_found = 1'b1;
        pick_idx   = j;
      end
    end
  end

  assign issue = (state_q == S_REPLAY) && replay_en && pick_found && credit_ok;
  // Returns with nothing outstanding, or inside the post-reset window, are stale.
  assign ret   = user_app_rd_valid && (ign_q == '0) && (outst_q != '0);
  assign push  = ret && (fifo_cnt_q != CNT_W'(OUT_DEPTH));

  // Next-state: mode FSM, store writes, replay issue, credits and output FIFO head.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    left_d     = left_q;
    stored_d   = stored_q;
    ch_full_d  = ch_full_q;
    ch_done_d  = ch_done_q;
    ovf_d      = ovf_q;
    last_d     = last_q;
    wr_cmd_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_cmd_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    ign_d      = (ign_q != '0) ? ign_q - 7'd1 : ign_q;

    case (state_q)
      S_IDLE: begin
        if (store_en && init_calib_complete) begin
          state_d   = S_STORE;
          ch_full_d = '0;
          stored_d  = '0;
          for (int c = 0; c < NUM_CH; c++) wptr_d[c] = cfg_base[c*AW +: AW];
        end else if (replay_en && init_calib_complete && (|stored_q) && (ign_q == '0)) begin
          state_d   = S_REPLAY;
          ch_done_d = ~stored_q;
          last_d    = CH_W'(NUM_CH - 1);
          for (int c = 0; c < NUM_CH; c++) begin
            rptr_d[c] = cfg_base[c*AW +: AW];
            left_d[c] = cfg_loops[c*LOOP_WIDTH +: LOOP_WIDTH];
          end
        end
      end
      S_STORE:  if (!store_en) state_d = S_IDLE;
      S_REPLAY: if (!replay_en || (&ch_done_q)) state_d = S_DRAIN;
      S_DRAIN:  if ((outst_q == '0) && (fifo_cnt_q == '0)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    for (int c = 0; c < NUM_CH; c++) begin
      if (accept && (tuple_in_ch == CH_W'(c))) begin
        wr_cmd_d    = 1'b1;
        wr_addr_d   = wptr_q[c];
        wr_data_d   = 144'({tuple_in_ch, tuple_in_data, tuple_in_len});
        wptr_d[c]   = wptr_q[c] + AW'(1);
        stored_d[c] = 1'b1;
        if (wptr_q[c] == cfg_limit[c*AW +: AW]) ch_full_d[c] = 1'b1;
      end
      if (issue && (pick_idx == c)) begin
        rd_cmd_d  = 1'b1;
        rd_addr_d = rptr_q[c];
        last_d    = CH_W'(c);
        if ((rptr_q[c] + AW'(1)) == wptr_q[c]) begin
          rptr_d[c] = cfg_base[c*AW +: AW];
          if (cfg_loops[c*LOOP_WIDTH +: LOOP_WIDTH] != '0) begin
            left_d[c] = left_q[c] - LOOP_WIDTH'(1);
            if (left_q[c] == LOOP_WIDTH'(1)) ch_done_d[c] = 1'b1;
          end
        end else begin
          rptr_d[c] = rptr_q[c] + AW'(1);
        end
      end
    end

    if (ret && !push) ovf_d = 1'b1;

    outst_d       = outst_q + CNT_W'(issue) - CNT_W'(ret);
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    fifo_rd_d     = fifo_rd_q + PTR_W'(pop);
    fifo_wr_d     = fifo_wr_q + PTR_W'(push);
    cnt_after_pop = fifo_cnt_q - CNT_W'(pop);
    out_vld_d     = (fifo_cnt_d != '0);
    // The registered head comes from memory, or straight from the return when the FIFO empties.
    if (cnt_after_pop != '0)  out_pay_d = fifo_mem[fifo_rd_d];
    else if (push)            out_pay_d = rd_pay;
    else                      out_pay_d = out_pay_q;

    busy_d = (state_d != S_IDLE);
  end

  // All state and registered outputs; resetn and sw_rst both return to IDLE with everything cleared.
  always_ff @(posedge qdr_clk) begin
    if (!resetn || sw_rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      left_q     <= '0;
      stored_q   <= '0;
      ch_full_q  <= '0;
      ch_done_q  <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      ign_q      <= 7'd64;
      wr_cmd_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_cmd_q   <= 1'b0;
      rd_addr_q  <= '0;
      out_vld_q  <= 1'b0;
      out_pay_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      left_q     <= left_d;
      stored_q   <= stored_d;
      ch_full_q  <= ch_full_d;
      ch_done_q  <= ch_done_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      outst_q    <= outst_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      ign_q      <= ign_d;
      wr_cmd_q   <= wr_cmd_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_cmd_q   <= rd_cmd_d;
      rd_addr_q  <= rd_addr_d;
      out_vld_q  <= out_vld_d;
      out_pay_q  <= out_pay_d;
    end
  end

  // Output FIFO storage; occupancy lives in the counters, so no reset is needed here.
  always_ff @(posedge qdr_clk) begin
    if (push) fifo_mem[fifo_wr_q] <= rd_pay;
  end

  assign ch_done          = ch_done_q;
  assign ch_full          = ch_full_q;
  assign busy             = busy_q;
  assign ovf_err          = ovf_q;
  assign user_app_wr_cmd  = wr_cmd_q;
  assign user_app_wr_addr = wr_addr_q;
  assign user_app_wr_data = wr_data_q;
  assign user_app_rd_cmd  = rd_cmd_q;
  assign user_app_rd_addr = rd_addr_q;
  assign tuple_out_vld    = out_vld_q;
  assign tuple_out_len    = out_pay_q[PKT_LEN_WIDTH-1:0];
  assign tuple_out_data   = out_pay_q[PKT_LEN_WIDTH +: PKT_TUPLE_WIDTH];
  assign tuple_out_ch     = out_pay_q[PKT_LEN_WIDTH+PKT_TUPLE_WIDTH +: CH_W];
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dflow_replay_engine_mc.sv
// Bench for dflow_replay_engine_mc (two channels): directed store vectors, replay
// ordering, backpressure, mid-replay stop and soft reset, with a small QDR model.
module tb_dflow_replay_engine_mc;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 4;
  localparam int TW     = 104;
  localparam int LW     = 16;
  localparam int AW     = 19;
  localparam int LPW    = 16;
  localparam int DEPTH  = 32;
  localparam int PAY_W  = TW + LW + CH_W;

  // ---------------- clock / reset / signals ----------------
  logic qdr_clk = 1'b0;
  always #5 qdr_clk = ~qdr_clk;

  logic                    resetn = 1'b0, sw_rst = 1'b0;
  logic                    store_en = 1'b0, replay_en = 1'b0, init_calib_complete = 1'b0;
  logic [NUM_CH*AW-1:0]    cfg_base, cfg_limit;
  logic [NUM_CH*LPW-1:0]   cfg_loops = '0;
  logic [NUM_CH-1:0]       ch_done, ch_full;
  logic                    busy, ovf_err;
  logic                    user_app_wr_cmd, user_app_rd_cmd, user_app_rd_valid;
  logic [AW-1:0]           user_app_wr_addr, user_app_rd_addr;
  logic [143:0]            user_app_wr_data, user_app_rd_data;
  logic [TW-1:0]           tuple_in_data = '0, tuple_out_data;
  logic [LW-1:0]           tuple_in_len = '0, tuple_out_len;
  logic [CH_W-1:0]         tuple_in_ch = '0, tuple_out_ch;
  logic                    tuple_in_vld = 1'b0, tuple_in_ready, tuple_out_vld;
  logic                    tuple_out_ready = 1'b0;
  logic [1:0]              dbg_state;

  logic                    rsp_valid = 1'b0, inj_valid = 1'b0;
  logic [143:0]            rsp_data = '0;
  assign user_app_rd_valid = rsp_valid | inj_valid;
  assign user_app_rd_data  = rsp_data;
  assign cfg_base  = {19'h00100, 19'h00000};
  assign cfg_limit = {19'h001FF, 19'h0000F};

  dflow_replay_engine_mc #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .PKT_TUPLE_WIDTH(TW), .PKT_LEN_WIDTH(LW),
    .QDR_ADDR_WIDTH(AW), .LOOP_WIDTH(LPW), .OUT_DEPTH(DEPTH)
  ) dut (
    .qdr_clk(qdr_clk), .resetn(resetn), .sw_rst(sw_rst),
    .store_en(store_en), .replay_en(replay_en),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_loops(cfg_loops),
    .ch_done(ch_done), .ch_full(ch_full), .busy(busy), .ovf_err(ovf_err),
    .init_calib_complete(init_calib_complete),
    .user_app_wr_cmd(user_app_wr_cmd), .user_app_wr_addr(user_app_wr_addr),
    .user_app_wr_data(user_app_wr_data),
    .user_app_rd_cmd(user_app_rd_cmd), .user_app_rd_addr(user_app_rd_addr),
    .user_app_rd_valid(user_app_rd_valid), .user_app_rd_data(user_app_rd_data),
    .tuple_in_data(tuple_in_data), .tuple_in_len(tuple_in_len), .tuple_in_ch(tuple_in_ch),
    .tuple_in_vld(tuple_in_vld), .tuple_in_ready(tuple_in_ready),
    .tuple_out_data(tuple_out_data), .tuple_out_len(tuple_out_len), .tuple_out_ch(tuple_out_ch),
    .tuple_out_vld(tuple_out_vld), .tuple_out_ready(tuple_out_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0, n_fail = 0;
  logic [PAY_W-1:0] exp_q[$];
  logic [AW-1:0]    exp_rd_q[$];
  logic             sb_en = 1'b0, rd_chk_en = 1'b0;
  int               rd_cnt = 0, pop_cnt = 0, ch0_cnt = 0, ch1_cnt = 0;
  int               qdr_lat = 3;
  logic [143:0]     qmem [int];
  logic             pipe_v [64];
  logic [AW-1:0]    pipe_a [64];

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [TW-1:0]   tuple;
    logic [LW-1:0]   len;
    logic            exp_wr;
    logic [AW-1:0]   exp_addr;
  } vec_t;
  vec_t vec [6];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk_tuple(input int i);
    return {32'hC0A80001 + 32'(i), 32'h0A000001, 16'(1000 + i), 16'd80, 8'd6};
  endfunction

  function automatic logic [PAY_W-1:0] pay_of(input vec_t v);
    return {v.ch, v.tuple, v.len};
  endfunction

  task automatic tick();
    @(posedge qdr_clk);
    #1;
  endtask

  task automatic drive_in(input logic [CH_W-1:0] ch, input logic [TW-1:0] t, input logic [LW-1:0] l);
    tuple_in_vld  = 1'b1;
    tuple_in_ch   = ch;
    tuple_in_data = t;
    tuple_in_len  = l;
  endtask

  task automatic set_vec(input int i, input logic [CH_W-1:0] ch, input logic wr, input logic [AW-1:0] a);
    vec[i].ch       = ch;
    vec[i].tuple    = mk_tuple(i);
    vec[i].len      = LW'(64 + 10 * i);
    vec[i].exp_wr   = wr;
    vec[i].exp_addr = a;
  endtask

  // ---------------- QDR model and output monitor (negedge, away from the active edge) ----------------
  initial for (int i = 0; i < 64; i++) begin pipe_v[i] = 1'b0; pipe_a[i] = '0; end

  always @(negedge qdr_clk) begin
    if (user_app_wr_cmd) qmem[int'(user_app_wr_addr)] = user_app_wr_data;
    if (user_app_rd_cmd) begin
      rd_cnt++;
      if (rd_chk_en) begin
        if (exp_rd_q.size() == 0) chk("rd_addr_extra", 1, 0);
        else chk("rd_addr", user_app_rd_addr, exp_rd_q.pop_front());
      end
    end
    for (int i = 63; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_a[i] = pipe_a[i-1]; end
    pipe_v[0] = user_app_rd_cmd;
    pipe_a[0] = user_app_rd_addr;
    rsp_valid = pipe_v[qdr_lat-1];
    rsp_data  = qmem.exists(int'(pipe_a[qdr_lat-1])) ? qmem[int'(pipe_a[qdr_lat-1])] : '0;
    if (tuple_out_vld && tuple_out_ready) begin
      pop_cnt++;
      if (tuple_out_ch == 0) ch0_cnt++; else ch1_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_payload", {tuple_out_ch, tuple_out_data, tuple_out_len}, exp_q.pop_front());
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic seen, prev_vld;
    logic [TW-1:0] held;

    // Store vectors: ch0,ch0,ch1,ch0,ch1 then an out-of-range channel that is swallowed.
    set_vec(0, 4'd0, 1'b1, 19'h00000);
    set_vec(1, 4'd0, 1'b1, 19'h00001);
    set_vec(2, 4'd1, 1'b1, 19'h00100);
    set_vec(3, 4'd0, 1'b1, 19'h00002);
    set_vec(4, 4'd1, 1'b1, 19'h00101);
    set_vec(5, 4'd5, 1'b0, 19'h00000);

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", tuple_in_ready, 0);
    chk("rst_status", {ch_done, ch_full, ovf_err}, 0);
    chk("rst_cmds", {user_app_wr_cmd, user_app_rd_cmd, tuple_out_vld}, 0);
    chk("rst_wr_addr", user_app_wr_addr, 0);
    resetn = 1'b1;
    init_calib_complete = 1'b1;
    repeat (70) tick();   // clear the post-reset return-ignore window

    // Store session 1: fill ch0 window (0x0..0xF)
    store_en = 1'b1;
    tick();
    chk("store_busy", busy, 1);
    chk("store_state", dbg_state, 1);
    for (int i = 0; i < 16; i++) begin
      drive_in(4'd0, mk_tuple(100 + i), LW'(i));
      chk("fill_ready", tuple_in_ready, 1);
      tick();
      chk("fill_wr_addr", {user_app_wr_cmd, user_app_wr_addr}, {1'b1, AW'(i)});
    end
    chk("full_ready0", tuple_in_ready, 0);
    chk("full_flag", ch_full, 2'b01);
    tick();
    chk("full_no_write", user_app_wr_cmd, 0);
    tuple_in_ch = 4'd1;
    #1;
    chk("full_ch1_ready", tuple_in_ready, 1);
    tick();
    chk("full_ch1_addr", {user_app_wr_cmd, user_app_wr_addr}, {1'b1, 19'h00100});
    tuple_in_vld = 1'b0;
    store_en = 1'b0;
    tick();
    chk("store_exit_busy", busy, 0);

    // Store session 2: table-driven vectors, windows restart at base
    store_en = 1'b1;
    tick();
    chk("restore_full_clr", ch_full, 0);
    for (int i = 0; i < 6; i++) begin
      drive_in(vec[i].ch, vec[i].tuple, vec[i].len);
      chk("vec_ready", tuple_in_ready, 1);
      tick();
      chk("vec_wr_cmd", user_app_wr_cmd, vec[i].exp_wr);
      if (vec[i].exp_wr) begin
        chk("vec_wr_addr", user_app_wr_addr, vec[i].exp_addr);
        chk("vec_wr_data", user_app_wr_data, {20'b0, pay_of(vec[i])});
      end
    end
    tuple_in_vld = 1'b0;
    tick();
    chk("vec_idle_wr", user_app_wr_cmd, 0);
    store_en = 1'b0;
    tick();

    // Replay loops0=2, loops1=1: round-robin, ch1 finishes first
    cfg_loops = {16'd1, 16'd2};
    qdr_lat = 3;
    tuple_out_ready = 1'b1;
    foreach (vec[i]) if (i == 0) begin end
    exp_rd_q = '{19'h0, 19'h100, 19'h1, 19'h101, 19'h2, 19'h0, 19'h1, 19'h2};
    exp_q.push_back(pay_of(vec[0])); exp_q.push_back(pay_of(vec[2]));
    exp_q.push_back(pay_of(vec[1])); exp_q.push_back(pay_of(vec[4]));
    exp_q.push_back(pay_of(vec[3])); exp_q.push_back(pay_of(vec[0]));
    exp_q.push_back(pay_of(vec[1])); exp_q.push_back(pay_of(vec[3]));
    sb_en = 1'b1; rd_chk_en = 1'b1; ch0_cnt = 0; ch1_cnt = 0;
    replay_en = 1'b1;
    tick();
    chk("replay_entry_rd", user_app_rd_cmd, 0);
    chk("replay_state", dbg_state, 2);
    tick();
    chk("first_rd", {user_app_rd_cmd, user_app_rd_addr}, {1'b1, 19'h0});
    seen = 1'b0; prev_vld = tuple_out_vld;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (user_app_rd_valid) begin
        seen = 1'b1;
        chk("out_latency_vld", tuple_out_vld, 1);
        chk("out_latency_prev", prev_vld, 0);
      end
      prev_vld = tuple_out_vld;
    end
    chk("first_return_seen", seen, 1);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("replay_idle", {busy, dbg_state}, 0);
    chk("replay_done", ch_done, 2'b11);
    chk("replay_ch0_cnt", ch0_cnt, 6);
    chk("replay_ch1_cnt", ch1_cnt, 2);
    chk("replay_exp_left", exp_q.size(), 0);
    chk("replay_rd_left", exp_rd_q.size(), 0);
    sb_en = 1'b0; rd_chk_en = 1'b0;
    replay_en = 1'b0;
    tick();

    // Backpressure: infinite loops, QDR latency 20, output never ready for 200 cycles
    cfg_loops = '0;
    qdr_lat = 20;
    tuple_out_ready = 1'b0;
    rd_cnt = 0; pop_cnt = 0;
    held = '0;
    replay_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 60) held = tuple_out_data;
    end
    chk("bp_reads", rd_cnt, DEPTH);
    chk("bp_ovf", ovf_err, 0);
    chk("bp_vld", tuple_out_vld, 1);
    chk("bp_hold", tuple_out_data, held);
    chk("bp_not_done", ch_done, 0);
    replay_en = 1'b0;
    tick();
    chk("bp_drain_state", dbg_state, 3);
    tuple_out_ready = 1'b1;
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("bp_idle", busy, 0);
    chk("bp_pops", pop_cnt, DEPTH);
    chk("bp_reads_final", rd_cnt, DEPTH);
    chk("bp_ovf_final", ovf_err, 0);

    // Drop replay_en with 5 reads in flight
    qdr_lat = 8;
    rd_cnt = 0; pop_cnt = 0; n = 0;
    replay_en = 1'b1;
    for (int i = 0; i < 50 && n < 5; i++) begin
      tick();
      if (user_app_rd_cmd) n++;
      if (n == 5) replay_en = 1'b0;
    end
    chk("stop_issued", n, 5);
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("stop_idle", busy, 0);
    chk("stop_reads", rd_cnt, 5);
    chk("stop_pops", pop_cnt, 5);
    tick();

    // Soft reset during STORE with ch0 full, then restart
    store_en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      drive_in(4'd0, mk_tuple(200 + i), LW'(i));
      tick();
    end
    chk("sw_pre_full", ch_full, 2'b01);
    sw_rst = 1'b1;
    tick();
    chk("sw_ready", tuple_in_ready, 0);
    chk("sw_busy", busy, 0);
    chk("sw_full", ch_full, 0);
    chk("sw_state", dbg_state, 0);
    sw_rst = 1'b0;
    tuple_in_vld = 1'b0;
    tick();
    chk("sw_restore_state", dbg_state, 1);
    drive_in(4'd0, mk_tuple(300), 16'd99);
    chk("sw_restore_ready", tuple_in_ready, 1);
    tick();
    chk("sw_restart_base", {user_app_wr_cmd, user_app_wr_addr}, {1'b1, 19'h0});
    tuple_in_vld = 1'b0;
    store_en = 1'b0;
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("stray_return_vld", tuple_out_vld, 0);
    chk("stray_return_ovf", ovf_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: a hung run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
